// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg
// Shared definitions for the programmable clock-divider controller.
//   fgState   : controller state encoding (IDLE, RUN, DRAIN)
//   LIMIT_MIN : smallest period length that can produce a real square wave
//   CLK_HZ    : nominal InputCLK frequency
//   hzToLimit : converts a target frequency to a CfgLimit value
package freq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fgState;

  localparam int unsigned LIMIT_MIN = 2;
  localparam int unsigned CLK_HZ    = 100000000;

  // Constant function for instantiators; f must be non-zero.
  function automatic int unsigned hzToLimit(input int unsigned f);
    return CLK_HZ / f;
  endfunction

endpackage

// File: rtl/period_counter.sv
// period_counter
// Period counter for freq_gen_ctrl. It counts 0..limit-1 while enabled and
// produces the registered divided-clock level from the next count value, so
// the level stays aligned with the count register.
//   InputCLK : clock
//   nReset   : asynchronous active-low reset
//   enable   : advance the count this cycle
//   clear    : force the count to 0 and the clock level low (wins over enable)
//   limit    : active period length L (>= 2)
//   wrap     : count is at L-1 (last cycle of the period)
//   clkCmp   : registered divided clock, high for counts >= L>>1
module period_counter
  import freq_gen_pkg::*;
#(
  parameter int unsigned CNT_BITS = 20
) (
  input  logic                InputCLK,
  input  logic                nReset,
  input  logic                enable,
  input  logic                clear,
  input  logic [CNT_BITS-1:0] limit,
  output logic                wrap,
  output logic                clkCmp
);

  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cntNext;

  assign wrap    = (cnt == (limit - CNT_BITS'(1)));
  assign cntNext = wrap ? '0 : (cnt + CNT_BITS'(1));

  always_ff @(posedge InputCLK or negedge nReset) begin
    if (!nReset) begin
      cnt    <= '0;
      clkCmp <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      clkCmp <= 1'b0;
    end else if (enable) begin
      cnt    <= cntNext;
      // After a wrap the limit may change, but cntNext is then 0 and any
      // legal limit gives a low level, so comparing against the current
      // limit is always correct.
      clkCmp <= (cntNext >= (limit >> 1));
    end
  end

endmodule

// File: rtl/freq_gen_ctrl.sv
// freq_gen_ctrl
// Programmable clock divider: emits a square wave and a period-start strobe
// from InputCLK, with runtime period/burst configuration applied glitch-free
// at period boundaries.
//   InputCLK  : clock            nReset   : async active-low reset
//   CfgValid/CfgReady : config handshake carrying CfgLimit (L) and CfgBurst (N, 0 = continuous)
//   Start/Stop: run control      OutputCLK: divided clock
//   Tick      : period-start strobe        Busy: RUN or DRAIN
//   Done      : pulse on return to IDLE    CfgErr: pulse on rejected config
//
// state | meaning
// IDLE  | counter held at 0, configs load straight into the active registers
// RUN   | generating periods; configs wait in the shadow until the next wrap
// DRAIN | stop requested, finishing the current period
module freq_gen_ctrl
  import freq_gen_pkg::*;
#(
  parameter int unsigned CNT_BITS      = 20,
  parameter int unsigned BURST_BITS    = 8,
  parameter int unsigned DEFAULT_LIMIT = 1000000
) (
  input  logic                  InputCLK,
  input  logic                  nReset,
  input  logic                  CfgValid,
  output logic                  CfgReady,
  input  logic [CNT_BITS-1:0]   CfgLimit,
  input  logic [BURST_BITS-1:0] CfgBurst,
  input  logic                  Start,
  input  logic                  Stop,
  output logic                  OutputCLK,
  output logic                  Tick,
  output logic                  Busy,
  output logic                  Done,
  output logic                  CfgErr
);

  fgState                state, stateNext;
  logic [CNT_BITS-1:0]   limitQ, limitNext;
  logic [CNT_BITS-1:0]   shadowLimit, shadowLimitNext;
  logic [BURST_BITS-1:0] burstQ, burstNext;
  logic [BURST_BITS-1:0] remainQ, remainNext;
  logic [BURST_BITS-1:0] shadowBurst, shadowBurstNext;
  logic                  cfgReadyQ, cfgReadyNext;
  logic                  tickQ, tickNext;
  logic                  busyQ, busyNext;
  logic                  doneQ, doneNext;
  logic                  errQ, errNext;
  logic                  cntEnable, cntClear, wrap, clkCmp;
  logic                  xfer, cfgOk, go, finish;

  period_counter #(
    .CNT_BITS(CNT_BITS)
  ) uCounter (
    .InputCLK(InputCLK),
    .nReset  (nReset),
    .enable  (cntEnable),
    .clear   (cntClear),
    .limit   (limitQ),
    .wrap    (wrap),
    .clkCmp  (clkCmp)
  );

  always_comb begin
    xfer            = CfgValid && cfgReadyQ;
    cfgOk           = xfer && (CfgLimit >= CNT_BITS'(LIMIT_MIN));
    errNext         = xfer && !cfgOk;
    go              = Start && !Stop;
    finish          = 1'b0;
    stateNext       = state;
    limitNext       = limitQ;
    burstNext       = burstQ;
    remainNext      = remainQ;
    shadowLimitNext = shadowLimit;
    shadowBurstNext = shadowBurst;
    cfgReadyNext    = cfgReadyQ;
    cntEnable       = 1'b0;
    cntClear        = 1'b0;

    unique case (state)
      IDLE: begin
        cntClear = 1'b1;
        if (cfgOk) begin
          limitNext = CfgLimit;
          burstNext = CfgBurst;
        end
        if (go) begin
          stateNext  = RUN;
          remainNext = cfgOk ? CfgBurst : burstQ;
        end
      end
      RUN, DRAIN: begin
        // A Stop sampled on the wrap cycle ends the run right there: the
        // current period is already complete.
        if (wrap) begin
          finish = (state == DRAIN) || Stop ||
                   ((burstQ != '0) && (remainQ == BURST_BITS'(1)));
        end else if ((state == RUN) && Stop) begin
          stateNext = DRAIN;
        end

        if (finish) begin
          stateNext = IDLE;
          cntClear  = 1'b1;
        end else begin
          cntEnable = 1'b1;
        end

        if (wrap && (burstQ != '0)) begin
          remainNext = remainQ - BURST_BITS'(1);
        end

        // Shadow full is the same as CfgReady low.
        if (wrap && !cfgReadyQ) begin
          limitNext    = shadowLimit;
          burstNext    = shadowBurst;
          remainNext   = shadowBurst;
          cfgReadyNext = 1'b1;
        end

        // A config arriving on the cycle the run ends goes straight to the
        // active registers so nothing is left stranded in the shadow.
        if (cfgOk) begin
          if (finish) begin
            limitNext = CfgLimit;
            burstNext = CfgBurst;
          end else begin
            shadowLimitNext = CfgLimit;
            shadowBurstNext = CfgBurst;
            cfgReadyNext    = 1'b0;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        cntClear  = 1'b1;
      end
    endcase

    busyNext = (stateNext != IDLE);
    tickNext = busyNext && (cntClear || wrap);
    doneNext = (state != IDLE) && (stateNext == IDLE);
  end

  always_ff @(posedge InputCLK or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      limitQ      <= CNT_BITS'(DEFAULT_LIMIT);
      burstQ      <= '0;
      remainQ     <= '0;
      shadowLimit <= '0;
      shadowBurst <= '0;
      cfgReadyQ   <= 1'b1;
      tickQ       <= 1'b0;
      busyQ       <= 1'b0;
      doneQ       <= 1'b0;
      errQ        <= 1'b0;
    end else begin
      state       <= stateNext;
      limitQ      <= limitNext;
      burstQ      <= burstNext;
      remainQ     <= remainNext;
      shadowLimit <= shadowLimitNext;
      shadowBurst <= shadowBurstNext;
      cfgReadyQ   <= cfgReadyNext;
      tickQ       <= tickNext;
      busyQ       <= busyNext;
      doneQ       <= doneNext;
      errQ        <= errNext;
    end
  end

  assign OutputCLK = clkCmp;
  assign Tick      = tickQ;
  assign Busy      = busyQ;
  assign Done      = doneQ;
  assign CfgErr    = errQ;
  assign CfgReady  = cfgReadyQ;

endmodule

// File: tb/tb_freq_gen_ctrl.sv
// tb_freq_gen_ctrl
// Table-driven bench for freq_gen_ctrl. Each record holds the inputs for one
// clock cycle and the outputs expected just after that edge, packed as
// {OutputCLK, Tick, Busy, Done, CfgReady, CfgErr}. Asynchronous reset is
// exercised by a hand-written sequence at the end.
module tb_freq_gen_ctrl;

  localparam int CNT_BITS   = 20;
  localparam int BURST_BITS = 8;
  localparam int DEF_LIMIT  = 12;

  logic                  InputCLK = 1'b0;
  logic                  nReset   = 1'b0;
  logic                  CfgValid = 1'b0;
  logic [CNT_BITS-1:0]   CfgLimit = '0;
  logic [BURST_BITS-1:0] CfgBurst = '0;
  logic                  Start    = 1'b0;
  logic                  Stop     = 1'b0;
  logic                  CfgReady, OutputCLK, Tick, Busy, Done, CfgErr;

  freq_gen_ctrl #(
    .CNT_BITS     (CNT_BITS),
    .BURST_BITS   (BURST_BITS),
    .DEFAULT_LIMIT(DEF_LIMIT)
  ) dut (
    .InputCLK (InputCLK),
    .nReset   (nReset),
    .CfgValid (CfgValid),
    .CfgReady (CfgReady),
    .CfgLimit (CfgLimit),
    .CfgBurst (CfgBurst),
    .Start    (Start),
    .Stop     (Stop),
    .OutputCLK(OutputCLK),
    .Tick     (Tick),
    .Busy     (Busy),
    .Done     (Done),
    .CfgErr   (CfgErr)
  );

  always #5 InputCLK = ~InputCLK;

  typedef struct {
    string      name;
    logic       cv;
    int         lim;
    int         bur;
    logic       st;
    logic       sp;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  function automatic logic [5:0] e(input logic clk, input logic tk, input logic busy,
                                   input logic done, input logic rdy, input logic err);
    return {clk, tk, busy, done, rdy, err};
  endfunction

  task automatic addV(input string nm, input logic cv, input int lim, input int bur,
                      input logic st, input logic sp, input logic [5:0] exp);
    vec_t v;
    v.name = nm; v.cv = cv; v.lim = lim; v.bur = bur; v.st = st; v.sp = sp; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Idle-input cycles of a running divider; displayed counts are first..first+n-1 mod L.
  task automatic addRun(input string nm, input int L, input int first, input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      int c;
      c = (first + k) % L;
      addV(nm, 1'b0, 0, 0, 1'b0, 1'b0, e(c >= L / 2, c == 0, 1'b1, 1'b0, rdy, 1'b0));
    end
  endtask

  task automatic checkOut(input string nm, input logic [5:0] exp);
    logic [5:0] got;
    got = {OutputCLK, Tick, Busy, Done, CfgReady, CfgErr};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: clk/tick/busy/done/rdy/err got %b required %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge InputCLK);
    #1;
  endtask

  localparam logic [5:0] IDLE_OUT = 6'b000010;

  initial begin
    // IDLE corner cases
    addV("idle",       0, 0, 0, 0, 0, IDLE_OUT);
    addV("stopIdle",   0, 0, 0, 0, 1, IDLE_OUT);
    addV("startStop",  0, 0, 0, 1, 1, IDLE_OUT);
    // L=4 continuous, stop in the middle of a period
    addV("t1cfg",      1, 4, 0, 0, 0, IDLE_OUT);
    addV("t1start",    0, 0, 0, 1, 0, e(0, 1, 1, 0, 1, 0));
    addRun("t1run", 4, 1, 13, 1'b1);
    addV("t1stop",     0, 0, 0, 0, 1, e(1, 0, 1, 0, 1, 0));
    addV("t1drain",    0, 0, 0, 0, 0, e(1, 0, 1, 0, 1, 0));
    addV("t1done",     0, 0, 0, 0, 0, e(0, 0, 0, 1, 1, 0));
    addV("t1idle",     0, 0, 0, 0, 0, IDLE_OUT);
    // L=5 burst of 3, config and start in the same cycle; Stop on the final wrap
    addV("t2cfgStart", 1, 5, 3, 1, 0, e(0, 1, 1, 0, 1, 0));
    addRun("t2run", 5, 1, 14, 1'b1);
    addV("t2done",     0, 0, 0, 0, 1, e(0, 0, 0, 1, 1, 0));
    addV("t2idle",     0, 0, 0, 0, 0, IDLE_OUT);
    // rejected configs leave L=5, N=3 in force
    addV("t5lim1",     1, 1, 0, 0, 0, e(0, 0, 0, 0, 1, 1));
    addV("t5lim0",     1, 0, 7, 0, 0, e(0, 0, 0, 0, 1, 1));
    addV("t5quiet",    0, 0, 0, 0, 0, IDLE_OUT);
    addV("t5start",    0, 0, 0, 1, 0, e(0, 1, 1, 0, 1, 0));
    addRun("t5run", 5, 1, 14, 1'b1);
    addV("t5done",     0, 0, 0, 0, 0, e(0, 0, 0, 1, 1, 0));
    addV("t5idle",     0, 0, 0, 0, 0, IDLE_OUT);
    // L=6 continuous, reconfig to L=4 at cnt=2; later configs blocked while shadow full
    addV("t3cfgStart", 1, 6, 0, 1, 0, e(0, 1, 1, 0, 1, 0));
    addRun("t3run6", 6, 1, 8, 1'b1);
    addV("t3cfg4",     1, 4, 0, 0, 0, e(1, 0, 1, 0, 0, 0));
    addV("t3blocked",  1, 9, 0, 0, 0, e(1, 0, 1, 0, 0, 0));
    addV("t3blocked",  1, 9, 0, 0, 0, e(1, 0, 1, 0, 0, 0));
    addV("t3swap",     1, 9, 0, 0, 0, e(0, 1, 1, 0, 1, 0));
    addRun("t3run4", 4, 1, 9, 1'b1);
    addV("t3stop",     0, 0, 0, 0, 1, e(1, 0, 1, 0, 1, 0));
    addV("t3drain",    0, 0, 0, 0, 0, e(1, 0, 1, 0, 1, 0));
    addV("t3done",     0, 0, 0, 0, 0, e(0, 0, 0, 1, 1, 0));
    addV("t3idle",     0, 0, 0, 0, 0, IDLE_OUT);
    // L=8, Stop at cnt=1, Start held during DRAIN
    addV("t4cfgStart", 1, 8, 0, 1, 0, e(0, 1, 1, 0, 1, 0));
    addV("t4cnt1",     0, 0, 0, 0, 0, e(0, 0, 1, 0, 1, 0));
    addV("t4stop",     0, 0, 0, 0, 1, e(0, 0, 1, 0, 1, 0));
    for (int c = 3; c < 8; c++)
      addV("t4drainStart", 0, 0, 0, 1, 0, e(c >= 4, 0, 1, 0, 1, 0));
    addV("t4done",     0, 0, 0, 0, 0, e(0, 0, 0, 1, 1, 0));
    addV("t4idle",     0, 0, 0, 0, 0, IDLE_OUT);

    #12;
    nReset = 1'b1;
    #1;
    checkOut("reset", IDLE_OUT);

    foreach (vecs[i]) begin
      CfgValid = vecs[i].cv;
      CfgLimit = CNT_BITS'(vecs[i].lim);
      CfgBurst = BURST_BITS'(vecs[i].bur);
      Start    = vecs[i].st;
      Stop     = vecs[i].sp;
      step();
      checkOut(vecs[i].name, vecs[i].exp);
    end
    CfgValid = 1'b0;
    Start    = 1'b0;
    Stop     = 1'b0;

    // Async reset mid-period with OutputCLK high (active L=8)
    Start = 1'b1;
    step();
    checkOut("t6start", e(0, 1, 1, 0, 1, 0));
    Start = 1'b0;
    repeat (4) step();
    checkOut("t6high", e(1, 0, 1, 0, 1, 0));
    #2 nReset = 1'b0;
    #1 checkOut("t6async", IDLE_OUT);
    step();
    step();
    #2 nReset = 1'b1;
    step();
    checkOut("t6idleAfter", IDLE_OUT);
    // Default limit with continuous burst after reset
    Start = 1'b1;
    step();
    checkOut("t6defStart", e(0, 1, 1, 0, 1, 0));
    Start = 1'b0;
    for (int k = 1; k <= DEF_LIMIT; k++) begin
      int c;
      c = k % DEF_LIMIT;
      step();
      checkOut("t6defRun", e(c >= DEF_LIMIT / 2, c == 0, 1'b1, 1'b0, 1'b1, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_gen_ctrl.md
Name: freq_gen_ctrl

Overview:
- Programmable clock-divider controller for the SoC utilities layer.
- Generates a square-wave OutputCLK and a period-start Tick strobe from InputCLK.
- Period and burst length are set at runtime through a valid/ready config port, so no rebuild is needed per frequency.
- Sequences start, stop, finite bursts and glitch-free reconfiguration at period boundaries.

Parameters:
- CNT_BITS, 20, width of the period counter and limit.
- BURST_BITS, 8, width of the burst-period count.
- DEFAULT_LIMIT, 1000000, period in InputCLK cycles after reset (100 Hz at 100 MHz).

Ports:
- InputCLK  in  1  system clock; the block's only clock.
- nReset  in  1  asynchronous, active-low reset.
- CfgValid  in  1  config request.
- CfgReady  out  1  config can be accepted.
- CfgLimit  in  CNT_BITS  period length L in InputCLK cycles.
- CfgBurst  in  BURST_BITS  number of periods N to emit; 0 = continuous.
- Start  in  1  begin generation (level sampled per cycle).
- Stop  in  1  request graceful stop.
- OutputCLK  out  1  divided clock.
- Tick  out  1  one-cycle strobe at each period start.
- Busy  out  1  high in RUN or DRAIN.
- Done  out  1  one-cycle pulse on return to IDLE.
- CfgErr  out  1  one-cycle pulse on a rejected config.

Behaviour:
- Reset state, applied asynchronously and immediately, including mid-period:
  - state IDLE; cnt 0; active limit DEFAULT_LIMIT; burst register 0; shadow empty.
  - OutputCLK 0; Tick 0; Done 0; CfgErr 0; Busy 0; CfgReady 1.
- All outputs are registered.
- States: IDLE, RUN, DRAIN.
- Counter:
  - In RUN/DRAIN, cnt counts 0..L-1 and wraps at L-1.
  - OutputCLK = (cnt >= L>>1), computed from the next cnt so it is aligned with the cnt register.
  - Low for floor(L/2) cycles, high for ceil(L/2) cycles.
- Tick = 1 exactly in cycles where state is RUN/DRAIN and cnt == 0.
- Config handshake:
  - A transfer occurs on a cycle with CfgValid & CfgReady.
  - If CfgLimit < 2: no state change, CfgErr = 1 on the next cycle, CfgReady stays 1.
  - In IDLE: a valid config loads the active limit and burst immediately.
  - In RUN/DRAIN: a valid config is latched into the shadow and CfgReady drops to 0. At the next wrap (cnt == L-1) the shadow becomes active, the burst remaining count reloads to the new N, the shadow clears, and CfgReady returns to 1 the cycle after.
- IDLE -> RUN on Start=1 and Stop=0:
  - Next cycle: cnt 0, Tick 1, Busy 1, OutputCLK 0.
  - Remaining = N, or "infinite" when N = 0.
  - Start & Stop together in IDLE: Stop wins, stay IDLE.
  - A config and Start in the same IDLE cycle: the config is applied first, and the run uses the new values.
- RUN:
  - Stop=1 -> DRAIN; the current period completes.
  - Start in RUN/DRAIN is ignored.
  - At wrap with N > 0, remaining decrements. When remaining reaches 0 (i.e. it was 1 at the wrap): go to IDLE.
  - Otherwise cnt -> 0 and a new period begins.
- DRAIN: at wrap -> IDLE; a pending shadow config is applied as the active config.
- Entering IDLE from RUN/DRAIN:
  - Next cycle: cnt 0, OutputCLK 0, Busy 0, Done 1 for exactly one cycle.
- Stop at the same wrap cycle where a burst ends: one Done only.
- Stop in IDLE: no effect, no Done.
- Width rules:
  - cnt and limit are CNT_BITS unsigned; the half value is limit>>1.
  - The maximum period is 2^CNT_BITS - 1.
  - The burst counter is BURST_BITS, so at most 2^BURST_BITS - 1 periods.

Decomposition:
- Package freq_gen_pkg:
  - state encoding (IDLE, RUN, DRAIN);
  - LIMIT_MIN = 2;
  - CLK_HZ = 100000000;
  - a constant function hz_to_limit(f) = CLK_HZ/f, used by instantiators to compute CfgLimit.
- Sub-module period_counter:
  - inputs: enable, clear, limit;
  - outputs: cnt, wrap flag, OutputCLK compare.
  - It keeps the FSM file free of counter arithmetic.

Test Plan:
1. Reset, CfgLimit=4, CfgBurst=0, Start pulse -> OutputCLK sequence 0,0,1,1 repeating; Tick every 4 cycles aligned with the first 0; Busy=1.
2. CfgLimit=5, CfgBurst=3, Start -> exactly 3 periods with OutputCLK 0,0,1,1,1; Tick pulses 3 times; Done is a single pulse 15 cycles after RUN entry; then IDLE with OutputCLK=0.
3. Continuous run at L=6, then a config at L=4 when cnt=2 -> CfgReady=0 until the wrap; the current period stays 6 cycles, later periods are 4; CfgReady=1 the cycle after the wrap.
4. Stop asserted at cnt=1 of an L=8 run -> OutputCLK completes the full 8-cycle period, then IDLE; one Done pulse; Start in DRAIN is ignored.
5. CfgLimit=1 in IDLE -> CfgErr pulse; active limit unchanged (the next run still uses the previous L).
6. nReset asserted mid-period while OutputCLK=1 -> OutputCLK, Busy and Tick are 0 immediately with no clock edge; after release the limit is DEFAULT_LIMIT and the state is IDLE.
